// File: rtl/noise_pkg.sv
// Shared definitions for the noise tester: sequencer state encoding and the
// default data widths also used by the error counter.
package noise_pkg;

    // Default widths, shared with the error counter.
    localparam int NOISE_CNT_W = 10;
    localparam int NOISE_ACC_W = 16;

    // Sequencer states, 3-bit encoding IDLE=0 .. DONE=7.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CLEAR     = 3'd1,
        ST_LAUNCH    = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_RUN       = 3'd4,
        ST_LATCH     = 3'd5,
        ST_GAP       = 3'd6,
        ST_DONE      = 3'd7
    } seq_state_t;

    // Larger of two elaboration-time integers (used for width sizing).
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/noise_test_sequencer_sat_accum.sv
// Saturating accumulator: adds a zero-extended input word to a W-bit total
// when enabled, sticking at all-ones instead of wrapping. Clear wins over add.
module sat_accum
    import noise_pkg::*;
#(
    parameter int W    = NOISE_ACC_W,
    parameter int IN_W = NOISE_CNT_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            en,
    input  logic [IN_W-1:0] din,
    output logic [W-1:0]    acc
);

    // One bit wider than the wider operand so the carry out is never lost,
    // even when the input word is wider than the accumulator.
    localparam int SW = max_int(W, IN_W) + 1;

    logic [SW-1:0] sum;

    // Full-width sum of the current total and the zero-extended input.
    always_comb begin
        sum = SW'(acc) + SW'(din);
    end

    // Accumulator register: clear, or add with saturation at all-ones.
    // NOTE: reset is synchronous (sampled on the clock edge) and all state
    // updates use non-blocking assignments so every register sees the
    // pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= (|sum[SW-1:W]) ? '1 : sum[W-1:0];
        end
    end

endmodule

// File: rtl/noise_test_sequencer.sv
// Noise test sequencer: on a start-button edge it runs RUNS back-to-back
// generator bursts (clear counter, launch, wait, latch errors, gap) and builds
// a summary of total errors, worst run and pass/fail. All outputs are
// registered; pulse outputs are derived from the next state so they line up
// with the state they belong to.
module noise_test_sequencer
    import noise_pkg::*;
#(
    parameter int RUNS       = 8,
    parameter int CNT_W      = NOISE_CNT_W,
    parameter int ACC_W      = NOISE_ACC_W,
    parameter int ERR_LIMIT  = 10,
    parameter int GAP_CYCLES = 64,
    parameter int TIMEOUT    = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_btn,
    input  logic             abort,
    input  logic             gen_busy,
    input  logic [CNT_W-1:0] err_count,
    output logic             gen_start,
    output logic             cnt_clr,
    output logic             busy,
    output logic             done,
    output logic [7:0]       run_idx,
    output logic [ACC_W-1:0] total_err,
    output logic [CNT_W-1:0] max_err,
    output logic             fail,
    output logic             timeout,
    output logic             aborted
);

    // One down-counter serves both the launch timeout and the inter-burst gap.
    localparam int               CTR_W      = $clog2(max_int(TIMEOUT, GAP_CYCLES) + 1);
    localparam logic [CTR_W-1:0] TIMEOUT_LD = CTR_W'(TIMEOUT);
    localparam logic [CTR_W-1:0] GAP_LD     = CTR_W'(GAP_CYCLES);
    localparam logic [7:0]       LAST_RUN   = 8'(RUNS - 1);

    seq_state_t       state;
    seq_state_t       state_next;
    logic             start_prev;
    logic             start_edge;
    logic [CTR_W-1:0] ctr;
    logic             ctr_last;
    logic             last_run;
    logic             over_limit;
    logic             do_start;
    logic             do_latch;
    logic             set_timeout;
    logic             set_aborted;

    assign start_edge = start_btn & ~start_prev;
    assign ctr_last   = (ctr == CTR_W'(1));
    assign last_run   = (run_idx == LAST_RUN);
    assign over_limit = (int'(err_count) > ERR_LIMIT);

    // Previous button level for rising-edge detection; tracks in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_prev <= 1'b0;
        end else begin
            start_prev <= start_btn;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and one-cycle action strobes; abort overrides all
    // transitions outside IDLE/DONE.
    // NOTE: every signal written here gets a default before the case, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next  = state;
        do_start    = 1'b0;
        do_latch    = 1'b0;
        set_timeout = 1'b0;
        set_aborted = 1'b0;
        if (abort && state != ST_IDLE && state != ST_DONE) begin
            state_next  = ST_DONE;
            set_aborted = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_edge) begin
                        state_next = ST_CLEAR;
                        do_start   = 1'b1;
                    end
                end
                ST_CLEAR:  state_next = ST_LAUNCH;
                ST_LAUNCH: state_next = ST_WAIT_BUSY;
                ST_WAIT_BUSY: begin
                    if (gen_busy) begin
                        state_next = ST_RUN;
                    end else if (ctr_last) begin
                        state_next  = ST_DONE;
                        set_timeout = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!gen_busy) begin
                        state_next = ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    do_latch   = 1'b1;
                    state_next = last_run ? ST_DONE : ST_GAP;
                end
                ST_GAP: begin
                    if (ctr_last) begin
                        state_next = ST_CLEAR;
                    end
                end
                ST_DONE:  state_next = ST_IDLE;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    // Shared down-counter: loaded on LAUNCH (timeout) and LATCH (gap),
    // decremented while waiting for the generator or idling in the gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctr <= '0;
        end else begin
            case (state)
                ST_LAUNCH:            ctr <= TIMEOUT_LD;
                ST_LATCH:             ctr <= GAP_LD;
                ST_WAIT_BUSY, ST_GAP: ctr <= ctr - CTR_W'(1);
                default:              ctr <= ctr;
            endcase
        end
    end

    // Registered control outputs, decoded from the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            gen_start <= 1'b0;
            cnt_clr   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            gen_start <= (state_next == ST_LAUNCH);
            cnt_clr   <= (state_next == ST_CLEAR);
            busy      <= (state_next != ST_IDLE);
            done      <= (state_next == ST_DONE);
        end
    end

    // Summary registers: cleared on a new start, updated once per run in
    // LATCH; status flags are sticky until the next start.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_idx <= '0;
            max_err <= '0;
            fail    <= 1'b0;
            timeout <= 1'b0;
            aborted <= 1'b0;
        end else begin
            if (do_start) begin
                run_idx <= '0;
                max_err <= '0;
                fail    <= 1'b0;
                timeout <= 1'b0;
                aborted <= 1'b0;
            end
            if (do_latch) begin
                if (err_count > max_err) begin
                    max_err <= err_count;
                end
                if (over_limit) begin
                    fail <= 1'b1;
                end
                if (!last_run) begin
                    run_idx <= run_idx + 8'd1;
                end
            end
            if (set_timeout) begin
                timeout <= 1'b1;
            end
            if (set_aborted) begin
                aborted <= 1'b1;
            end
        end
    end

    // Saturating total of the per-run error counts.
    sat_accum #(
        .W    (ACC_W),
        .IN_W (CNT_W)
    ) u_total (
        .clk (clk),
        .rst (rst),
        .clr (do_start),
        .en  (do_latch),
        .din (err_count),
        .acc (total_err)
    );

endmodule

// File: doc/noise_test_sequencer.md
# noise_test_sequencer

Sequencer for the noise tester. It runs a configurable number of back-to-back test bursts through the signal generator and, for each burst, clears the error counter, launches the generator and waits for it to finish. It then latches the per-run error count and builds a summary: total errors, worst run, and pass/fail. It sits between the start pushbutton and the signal-generator/error-counter pair, and replaces direct button-to-generator wiring.

## Interface
- RUNS, 8: bursts per test sequence (1..255).
- CNT_W, 10: width of the per-run error count from the error counter.
- ACC_W, 16: width of the total-error accumulator.
- ERR_LIMIT, 10: a run with more errors than this marks the sequence failed.
- GAP_CYCLES, 64: idle cycles between bursts (≥1).
- TIMEOUT, 1024: cycles allowed for `gen_busy` to rise after launch.

Ports (all signals synchronous to `clk`; upstream synchronizes any asynchronous source):
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start_btn  in  1  debounced, synchronized button level; a rising edge starts a sequence.
- abort  in  1  level; stops the sequence.
- gen_busy  in  1  generator enable (high while a burst is sent).
- err_count  in  CNT_W  error counter value, stable once `gen_busy` falls.
- gen_start  out  1  one-cycle pulse to the generator start.
- cnt_clr  out  1  one-cycle clear to the error counter.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of a sequence (normal, timeout or abort).
- run_idx  out  8  index of the current or last completed run.
- total_err  out  ACC_W  saturating sum of per-run errors.
- max_err  out  CNT_W  largest per-run error count.
- fail  out  1  sticky; set if any run exceeded ERR_LIMIT.
- timeout  out  1  sticky; the generator never went busy.
- aborted  out  1  sticky; the sequence ended by `abort`.

## Operation
FSM states: IDLE, CLEAR, LAUNCH, WAIT_BUSY, RUN, LATCH, GAP, DONE.
- **Reset:** state=IDLE. All outputs are 0; this includes the summary registers and the sticky flags.
- **IDLE:**
  - A rising edge of `start_btn` is detected with a registered previous level, which is 0 out of reset.
  - On the edge, zero `total_err`, `max_err`, `run_idx` and all sticky flags, then go to CLEAR.
  - A held button does not retrigger.
- **CLEAR:** `cnt_clr`=1 for this cycle → LAUNCH.
- **LAUNCH:** `gen_start`=1 for this cycle; load the timeout counter → WAIT_BUSY.
- **WAIT_BUSY:**
  - If `gen_busy`=1 → RUN.
  - Otherwise decrement the counter; on reaching 0, set `timeout` → DONE.
- **RUN:** wait for `gen_busy`=0 → LATCH. There is no timeout here, because the generator self-terminates.
- **LATCH (one cycle), using `err_count` sampled this cycle:**
  - `total_err` += zero-extended count, saturating at all-ones.
  - `max_err` = max(`max_err`, count).
  - `fail` |= (count > ERR_LIMIT).
  - If `run_idx`==RUNS-1 → DONE; else increment `run_idx`, load the gap counter → GAP.
- **GAP:** count down GAP_CYCLES → CLEAR.
- **DONE:** `done`=1 for one cycle → IDLE. Summary outputs hold until the next start.
- **abort:**
  - In any state other than IDLE/DONE, `abort`=1 forces DONE next cycle and sets `aborted`.
  - `gen_start`/`cnt_clr` are not asserted in that cycle.
  - Has priority over all other transitions. Ignored in IDLE.
- **Start while busy:** `start_btn` edges outside IDLE are ignored (the edge register still tracks).
- **rst mid-sequence:** immediate return to IDLE with all outputs cleared. No `done` pulse.

## Timing
- Start edge seen in cycle 0 → `busy` and `cnt_clr` high in cycle 1 → `gen_start` in cycle 2.
- `gen_busy` falls in cycle t → LATCH in cycle t+1 → summary registers updated at the t+2 edge.
- Between runs: LATCH(1) + GAP(GAP_CYCLES) + CLEAR(1) + LAUNCH(1), so `gen_start` pulses are spaced by burst time + GAP_CYCLES + 3.
- Last LATCH → DONE next cycle → `busy`=0 the cycle after `done`.
- Every output is registered; there are no combinational paths from input to output.

## Structure
- **Shared package `noise_pkg`:**
  - State encoding localparams (3-bit): IDLE=0 … DONE=7.
  - Default widths CNT_W and ACC_W, shared with the error counter.
- **Sub-module `sat_accum`:** ACC_W-bit saturating accumulator with clear and enable. It is natural to reuse for other totals.
- Everything else stays in the top module: FSM, timeout/gap down-counter (one shared counter), edge detect.

## Test plan
- **Nominal:** RUNS=3, generator model busy 1000 cycles, err_count 5, 0, 12 → 3 `gen_start` pulses, `total_err`=17, `max_err`=12, `fail`=1 (12>10), one `done`, `run_idx`=2.
- **No generator:** `gen_busy` held 0 → `timeout`=1 and `done` exactly TIMEOUT+3 cycles after the start edge; one `gen_start` only.
- **Saturation:** ACC_W=4, 3 runs of err_count 7 → `total_err`=15, not 5.
- **Abort in RUN of run 1** → `done` next cycle, `aborted`=1, `total_err` holds run 0 only; the next start edge clears all summaries.
- **Held button / start during RUN:** button held high across `done` → no second sequence; a new edge while busy → ignored.
- **rst asserted in GAP:** next cycle state=IDLE, all outputs 0, no `done`.
